// File: rtl/csr_trap_unit_pkg.sv
// csr_trap_unit_pkg: shared CSR addresses, trap codes, csr_op encodings, mstatus/mtvec fields and FSM state
package csr_trap_unit_pkg;
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;
  localparam logic [3:0] EXC_IADDR_MISALIGN = 4'd0;
  localparam logic [3:0] EXC_ILLEGAL_INSN   = 4'd2;
  localparam logic [3:0] EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0] EXC_LADDR_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_SADDR_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ECALL_M        = 4'd11;
  localparam logic [3:0] INT_MSI = 4'd3;
  localparam logic [3:0] INT_MTI = 4'd7;
  localparam logic [3:0] INT_MEI = 4'd11;
  typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam logic [1:0] MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MODE_VECTORED = 2'b01;
  typedef enum logic {IDLE, REDIR} state_e;
endpackage

// File: rtl/csr_trap_prio.sv
// csr_trap_prio: interrupt priority encoder; in gie + pend {ext,timer,sw}, out int_req + code (MEI > MSI > MTI)
module csr_trap_prio
  import csr_trap_unit_pkg::*;
(
  input  logic       gie,
  input  logic [2:0] pend,
  output logic       int_req,
  output logic [3:0] code
);
  assign int_req = gie & |pend;
  assign code = pend[2] ? INT_MEI : pend[0] ? INT_MSI : INT_MTI;
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: M-mode CSR file + trap sequencer; ports: commit_* in/ready out, rd_addr/rd_data/rd_illegal, irq_* in, redirect_* handshake to IF
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int         XLEN        = 64,
  parameter int         HARTID      = 0,
  parameter bit         VECTORED_EN = 1'b1,
  parameter logic [2:0] IRQ_EN_MASK = 3'b111
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            commit_exc,
  input  logic [3:0]      commit_cause,
  input  logic [XLEN-1:0] commit_tval,
  input  logic            commit_mret,
  input  logic            commit_csr_we,
  input  logic [1:0]      commit_csr_op,
  input  logic [11:0]     commit_csr_addr,
  input  logic [XLEN-1:0] commit_csr_wdata,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_illegal,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic            irq_ext,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc
);
  state_e state;
  logic mie_b, mpie, int_req, fire, trap;
  logic [1:0] mcinh, wmode;
  logic [2:0] mie_r, mip_r;
  logic [3:0] int_code;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret;
  logic [XLEN-1:0] mstatus_v, misa_v, nv, base, tvec;
  logic [XLEN-1:0] rv [2];
  function automatic logic [XLEN-1:0] irq_bits(input logic [2:0] v);
    return XLEN'({v[2], 3'b000, v[1], 3'b000, v[0], 3'b000});
  endfunction
  assign mstatus_v = XLEN'({2'b11, 3'b000, mpie, 3'b000, mie_b, 3'b000});
  assign misa_v = {(XLEN == 64) ? 2'd2 : 2'd1, (XLEN-2)'(13'h1100)};
  always_comb begin
    rd_illegal = 1'b0;
    for (int i = 0; i < 2; i++) begin
      case (i == 0 ? rd_addr : commit_csr_addr)
        CSR_MSTATUS:       rv[i] = mstatus_v;
        CSR_MISA:          rv[i] = misa_v;
        CSR_MIE:           rv[i] = irq_bits(mie_r);
        CSR_MTVEC:         rv[i] = mtvec;
        CSR_MCOUNTINHIBIT: rv[i] = XLEN'({mcinh[1], 1'b0, mcinh[0]});
        CSR_MSCRATCH:      rv[i] = mscratch;
        CSR_MEPC:          rv[i] = mepc;
        CSR_MCAUSE:        rv[i] = mcause;
        CSR_MTVAL:         rv[i] = mtval;
        CSR_MIP:           rv[i] = irq_bits(mip_r);
        CSR_MCYCLE:        rv[i] = mcycle;
        CSR_MINSTRET:      rv[i] = minstret;
        CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rv[i] = '0;
        CSR_MHARTID:       rv[i] = XLEN'(HARTID);
        default: begin
          rv[i] = '0;
          if (i == 0) rd_illegal = 1'b1;
        end
      endcase
    end
  end
  assign rd_data = rv[0];
  assign nv = commit_csr_op == OP_RW ? commit_csr_wdata :
              commit_csr_op == OP_RS ? rv[1] | commit_csr_wdata : rv[1] & ~commit_csr_wdata;
  assign wmode = (nv[1:0] == MODE_VECTORED && VECTORED_EN) ? MODE_VECTORED : MODE_DIRECT;
  csr_trap_prio u_prio (
    .gie(mie_b),
    .pend(mie_r & mip_r),
    .int_req(int_req),
    .code(int_code)
  );
  assign fire = commit_valid & commit_ready;
  assign trap = int_req | commit_exc;
  assign base = {mtvec[XLEN-1:2], 2'b00};
  // only interrupts are vectored; exceptions always land on the base
  assign tvec = (mtvec[1:0] == MODE_VECTORED && int_req) ? base + XLEN'({int_code, 2'b00}) : base;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      commit_ready <= 1'b1;
      redirect_valid <= 1'b0;
      redirect_pc <= '0;
      mie_b <= 1'b0;
      mpie <= 1'b0;
      mie_r <= '0;
      mip_r <= '0;
      mtvec <= '0;
      mscratch <= '0;
      mepc <= '0;
      mcause <= '0;
      mtval <= '0;
      mcycle <= '0;
      minstret <= '0;
      mcinh <= '0;
    end else begin
      mip_r <= {irq_ext, irq_timer, irq_sw} & IRQ_EN_MASK;
      if (!mcinh[0]) mcycle <= mcycle + XLEN'(1);
      if (state == REDIR) begin
        if (redirect_ready) begin
          state <= IDLE;
          commit_ready <= 1'b1;
          redirect_valid <= 1'b0;
        end
      end else if (fire) begin
        if (trap) begin
          mepc <= commit_pc;
          mcause <= int_req ? {1'b1, (XLEN-5)'(0), int_code} : XLEN'(commit_cause);
          mtval <= int_req ? '0 : commit_tval;
          mpie <= mie_b;
          mie_b <= 1'b0;
          redirect_pc <= tvec;
        end else begin
          if (!mcinh[1]) minstret <= minstret + XLEN'(1);
          if (commit_mret) begin
            mie_b <= mpie;
            mpie <= 1'b1;
            redirect_pc <= mepc;
          end else if (commit_csr_we) begin
            // later NBAs here override the counter increments above
            case (commit_csr_addr)
              CSR_MSTATUS: begin
                mie_b <= nv[MSTATUS_MIE];
                mpie <= nv[MSTATUS_MPIE];
              end
              CSR_MIE:           mie_r <= {nv[11], nv[7], nv[3]} & IRQ_EN_MASK;
              CSR_MTVEC:         mtvec <= {nv[XLEN-1:2], wmode};
              CSR_MCOUNTINHIBIT: mcinh <= {nv[2], nv[0]};
              CSR_MSCRATCH:      mscratch <= nv;
              CSR_MEPC:          mepc <= {nv[XLEN-1:2], 2'b00};
              CSR_MCAUSE:        mcause <= nv;
              CSR_MTVAL:         mtval <= nv;
              CSR_MCYCLE:        mcycle <= nv;
              CSR_MINSTRET:      minstret <= nv;
              default: ;
            endcase
          end
        end
        if (trap || commit_mret) begin
          state <= REDIR;
          commit_ready <= 1'b0;
          redirect_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed bench with a redirect scoreboard and immediate-assertion checks
module tb_csr_trap_unit;
  import csr_trap_unit_pkg::*;
  logic clk = 1'b0, rst = 1'b0;
  logic commit_valid, commit_ready, commit_exc, commit_mret, commit_csr_we;
  logic [63:0] commit_pc, commit_tval, commit_csr_wdata, rd_data, redirect_pc;
  logic [3:0] commit_cause;
  logic [1:0] commit_csr_op;
  logic [11:0] commit_csr_addr, rd_addr;
  logic rd_illegal, irq_sw, irq_timer, irq_ext, redirect_valid, redirect_ready;
  int compared = 0, mismatched = 0;
  logic [63:0] exp_redir [$];
  always #5 clk = ~clk;
  csr_trap_unit #(.XLEN(64), .HARTID(0), .VECTORED_EN(1'b1), .IRQ_EN_MASK(3'b111)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_pc(commit_pc),
    .commit_exc(commit_exc), .commit_cause(commit_cause), .commit_tval(commit_tval),
    .commit_mret(commit_mret), .commit_csr_we(commit_csr_we), .commit_csr_op(commit_csr_op),
    .commit_csr_addr(commit_csr_addr), .commit_csr_wdata(commit_csr_wdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_illegal(rd_illegal),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rdchk(input string tag, input logic [11:0] a, input logic [63:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask
  task automatic commit(input logic [63:0] pc, input logic exc, input logic [3:0] cause,
                        input logic [63:0] tval, input logic mret, input logic we,
                        input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
    int n = 0;
    commit_pc = pc; commit_exc = exc; commit_cause = cause; commit_tval = tval;
    commit_mret = mret; commit_csr_we = we; commit_csr_op = op; commit_csr_addr = a;
    commit_csr_wdata = wd; commit_valid = 1'b1;
    while (!commit_ready && n < 20) begin
      step(1);
      n++;
    end
    chk("commit_ready_before_accept", 64'(commit_ready), 64'd1);
    step(1);
    commit_valid = 1'b0; commit_exc = 1'b0; commit_mret = 1'b0; commit_csr_we = 1'b0;
  endtask
  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] wd);
    commit(64'h40, 1'b0, 4'd0, 64'd0, 1'b0, 1'b1, op, a, wd);
  endtask
  task automatic wait_redir(input int hold);
    int n = 0;
    logic [63:0] e;
    while (!redirect_valid && n < 20) begin
      step(1);
      n++;
    end
    chk("redirect_valid", 64'(redirect_valid), 64'd1);
    e = exp_redir.size() > 0 ? exp_redir.pop_front() : '1;
    chk("redirect_pc", redirect_pc, e);
    for (int i = 0; i < hold; i++) begin
      chk("hold_commit_ready", 64'(commit_ready), 64'd0);
      chk("hold_redirect_pc", redirect_pc, e);
      step(1);
    end
    redirect_ready = 1'b1;
    step(1);
    redirect_ready = 1'b0;
    chk("post_commit_ready", 64'(commit_ready), 64'd1);
    chk("post_redirect_valid", 64'(redirect_valid), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [63:0] e;
    {commit_valid, commit_exc, commit_mret, commit_csr_we, redirect_ready, irq_sw, irq_timer, irq_ext} = '0;
    commit_pc = '0; commit_cause = '0; commit_tval = '0; commit_csr_op = '0;
    commit_csr_addr = '0; commit_csr_wdata = '0; rd_addr = '0;
    step(3);
    chk("rst_commit_ready", 64'(commit_ready), 64'd1);
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);
    rst = 1'b1;
    rdchk("rst_mstatus", CSR_MSTATUS, 64'h1800);
    rdchk("rst_mtvec", CSR_MTVEC, 64'd0);
    rdchk("misa", CSR_MISA, 64'h8000_0000_0000_1100);
    chk("misa_legal", 64'(rd_illegal), 64'd0);
    rdchk("mhartid", CSR_MHARTID, 64'd0);
    rdchk("mvendorid", CSR_MVENDORID, 64'd0);
    rdchk("unknown_data", 12'h7C0, 64'd0);
    chk("unknown_illegal", 64'(rd_illegal), 64'd1);
    csr(OP_RW, CSR_MTVEC, 64'h1002);
    rdchk("mtvec_mode_warl", CSR_MTVEC, 64'h1000);
    csr(OP_RW, CSR_MEPC, 64'h103);
    rdchk("mepc_align", CSR_MEPC, 64'h100);
    csr(OP_RW, CSR_MIP, 64'h888);
    rdchk("mip_read_only", CSR_MIP, 64'd0);
    csr(OP_RW, CSR_MTVEC, 64'h8000_0001);
    rdchk("mtvec_vectored", CSR_MTVEC, 64'h8000_0001);
    csr(OP_RW, CSR_MIE, 64'h80);
    csr(OP_RW, CSR_MSTATUS, 64'h8);
    rdchk("mie", CSR_MIE, 64'h80);
    irq_timer = 1'b1;
    step(1);
    rdchk("mip_mtip", CSR_MIP, 64'h80);
    exp_redir.push_back(64'h8000_001C);
    commit(64'h100, 1'b0, 4'd0, 64'd0, 1'b0, 1'b0, 2'b00, 12'd0, 64'd0);
    wait_redir(0);
    irq_timer = 1'b0;
    rdchk("tmr_mepc", CSR_MEPC, 64'h100);
    rdchk("tmr_mcause", CSR_MCAUSE, 64'h8000_0000_0000_0007);
    rdchk("tmr_mstatus", CSR_MSTATUS, 64'h1880);
    rdchk("tmr_mtval", CSR_MTVAL, 64'd0);
    rdchk("tmr_minstret", CSR_MINSTRET, 64'd6);
    exp_redir.push_back(64'h8000_0000);
    commit(64'h200, 1'b1, 4'd11, 64'h55, 1'b0, 1'b0, 2'b00, 12'd0, 64'd0);
    wait_redir(3);
    rdchk("ecall_mepc", CSR_MEPC, 64'h200);
    rdchk("ecall_mcause", CSR_MCAUSE, 64'd11);
    rdchk("ecall_mtval", CSR_MTVAL, 64'h55);
    rdchk("ecall_minstret", CSR_MINSTRET, 64'd6);
    rdchk("ecall_mstatus", CSR_MSTATUS, 64'h1800);
    csr(OP_RW, CSR_MIE, 64'h888);
    csr(OP_RW, CSR_MSTATUS, 64'h8);
    irq_ext = 1'b1;
    irq_sw = 1'b1;
    step(1);
    exp_redir.push_back(64'h8000_002C);
    commit(64'h400, 1'b1, 4'd2, 64'h77, 1'b0, 1'b1, OP_RW, CSR_MSCRATCH, 64'hdead);
    wait_redir(0);
    irq_ext = 1'b0;
    irq_sw = 1'b0;
    rdchk("ext_mcause", CSR_MCAUSE, 64'h8000_0000_0000_000B);
    rdchk("ext_mtval", CSR_MTVAL, 64'd0);
    rdchk("ext_mepc", CSR_MEPC, 64'h400);
    rdchk("ext_csr_suppressed", CSR_MSCRATCH, 64'd0);
    rdchk("ext_mstatus", CSR_MSTATUS, 64'h1880);
    csr(OP_RW, CSR_MEPC, 64'h300);
    rdchk("pre_mret_minstret", CSR_MINSTRET, 64'd9);
    exp_redir.push_back(64'h300);
    commit(64'h500, 1'b0, 4'd0, 64'd0, 1'b1, 1'b0, 2'b00, 12'd0, 64'd0);
    wait_redir(0);
    rdchk("mret_mstatus", CSR_MSTATUS, 64'h1888);
    rdchk("mret_minstret", CSR_MINSTRET, 64'd10);
    csr(OP_RS, CSR_MCOUNTINHIBIT, 64'h1);
    csr(OP_RW, CSR_MCYCLE, '1);
    rdchk("mcycle_set", CSR_MCYCLE, '1);
    step(2);
    rdchk("mcycle_hold", CSR_MCYCLE, '1);
    csr(OP_RC, CSR_MCOUNTINHIBIT, 64'h1);
    rdchk("mcycle_hold_last", CSR_MCYCLE, '1);
    rdchk("mcycle_wrap", CSR_MCYCLE, 64'd0);
    rdchk("mcycle_inc", CSR_MCYCLE, 64'd1);
    csr(OP_RW, CSR_MCOUNTINHIBIT, 64'hFF);
    rdchk("mcountinhibit_mask", CSR_MCOUNTINHIBIT, 64'h5);
    csr(OP_RW, CSR_MSCRATCH, 64'h1234);
    rdchk("mscratch", CSR_MSCRATCH, 64'h1234);
    rdchk("minstret_inhibited", CSR_MINSTRET, 64'd14);
    exp_redir.push_back(64'h8000_0000);
    commit(64'h600, 1'b1, 4'd3, 64'd0, 1'b0, 1'b0, 2'b00, 12'd0, 64'd0);
    chk("pre_rst_redirect_valid", 64'(redirect_valid), 64'd1);
    e = exp_redir.size() > 0 ? exp_redir.pop_front() : '1;
    chk("pre_rst_redirect_pc", redirect_pc, e);
    rst = 1'b0;
    step(1);
    chk("mid_rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("mid_rst_commit_ready", 64'(commit_ready), 64'd1);
    chk("mid_rst_redirect_pc", redirect_pc, 64'd0);
    rdchk("mid_rst_mstatus", CSR_MSTATUS, 64'h1800);
    rdchk("mid_rst_mtvec", CSR_MTVEC, 64'd0);
    rdchk("mid_rst_mepc", CSR_MEPC, 64'd0);
    rdchk("mid_rst_mcause", CSR_MCAUSE, 64'd0);
    rdchk("mid_rst_mscratch", CSR_MSCRATCH, 64'd0);
    rdchk("mid_rst_mie", CSR_MIE, 64'd0);
    rdchk("mid_rst_minstret", CSR_MINSTRET, 64'd0);
    rdchk("mid_rst_mcycle", CSR_MCYCLE, 64'd0);
    rdchk("mid_rst_mcountinhibit", CSR_MCOUNTINHIBIT, 64'd0);
    rst = 1'b1;
    step(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Parametrised machine-mode CSR file and trap sequencer; successor to the fixed-width CSR/trap logic in the write-back stage.
- Adds three interrupt sources (software, timer, external) with fixed priority, vectored mtvec, mtval, mcountinhibit and WARL field masking.
- Adds a registered, back-pressured PC-redirect handshake toward IF.
- Sits at commit. WB presents one committing instruction per cycle. The block updates CSRs and arbitrates exception versus interrupt. It drives the new PC for trap entry and mret.

Parameters:
- XLEN, 64, datapath/CSR width (32 or 64).
- HARTID, 0, value returned by mhartid.
- VECTORED_EN, 1, 1 allows mtvec.MODE=01; 0 forces MODE=00.
- IRQ_EN_MASK, 3'b111, per-source implement mask {ext,timer,sw}. Unimplemented mie/mip bits read 0.

Ports:
- clk in 1: clock.
- rst in 1: reset, synchronous, active-low.
- commit_valid in 1: instruction presented at commit.
- commit_ready out 1: commit accepted this cycle.
- commit_pc in XLEN: pc of committing instruction.
- commit_exc in 1: instruction raised a synchronous exception.
- commit_cause in 4: exception code (0,2,3,4,6,11).
- commit_tval in XLEN: trap value for mtval.
- commit_mret in 1: instruction is mret.
- commit_csr_we in 1: CSR instruction writes.
- commit_csr_op in 2: 01 RW, 10 RS (set), 11 RC (clear).
- commit_csr_addr in 12: CSR address for write.
- commit_csr_wdata in XLEN: rs1/zimm operand.
- rd_addr in 12: CSR read address (from EXE).
- rd_data out XLEN: combinational read value.
- rd_illegal out 1: rd_addr is not an implemented CSR.
- irq_sw, irq_timer, irq_ext in 1 each: level interrupt requests.
- redirect_valid out 1: new PC pending.
- redirect_ready in 1: IF accepts redirect.
- redirect_pc out XLEN: trap target or mepc.

Behaviour:
- Reset (rst=0 at posedge) clears the following to 0: mstatus.MIE/MPIE, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret, mcountinhibit.
- Reset state for outputs and FSM:
  - FSM goes to IDLE.
  - redirect_valid=0 and redirect_pc=0.
  - commit_ready=1.
  - rd_data follows rd_addr with the reset values.
- Reset mid-redirect drops the pending redirect.
- mip:
  - MSIP(3), MTIP(7) and MEIP(11) are registered from the irq_* pins, one-cycle latency, masked by IRQ_EN_MASK.
  - mip is read-only; writes to it are ignored.
- Reads:
  - mstatus.MPP(12:11) reads 2'b11.
  - misa is read-only, MXL by XLEN, bits I and M set.
  - mvendorid, marchid and mimpid read 0.
  - mhartid returns HARTID.
  - Unknown address gives rd_data=0 and rd_illegal=1.
- Write operations: new = RW ? wdata : RS ? old|wdata : old&~wdata.
- Write masking:
  - mepc[1:0] is forced to 0.
  - For mtvec, MODE values >=2, or MODE=01 with VECTORED_EN=0, store MODE=00.
  - mcountinhibit keeps only bits 0 (CY) and 2 (IR).
  - Writes to read-only or unknown addresses are dropped silently.
- Interrupt pending: int_req = mstatus.MIE & |(mie & mip). Priority is MEI > MSI > MTI.
- FSM IDLE, when commit_valid=1 and commit_ready=1:
  - Priority order: interrupt > exception > mret > CSR write > plain retire.
  - Interrupt/exception:
    - mepc=commit_pc.
    - mcause: interrupt = {1, code 11/3/7}; exception = {0, commit_cause}.
    - mtval: commit_tval for exceptions, 0 for interrupts.
    - MPIE=MIE, MIE=0.
    - The instruction does not retire and its CSR write is suppressed.
    - Goes to REDIR.
  - mret:
    - MIE=MPIE, MPIE=1.
    - redirect_pc=mepc, using the value before this cycle's update.
    - minstret increments; goes to REDIR.
- redirect_pc target:
  - MODE=00, or any exception: {mtvec[XLEN-1:2],2'b00}.
  - MODE=01 and interrupt: base + 4*code.
- FSM REDIR:
  - redirect_valid=1, redirect_pc stable, commit_ready=0.
  - When redirect_valid & redirect_ready, go back to IDLE. commit_ready becomes 1 the next cycle.
- Counters:
  - mcycle increments each cycle unless mcountinhibit.CY=1.
  - minstret increments per retired instruction unless mcountinhibit.IR=1.
  - A CSR write to a counter in the same cycle wins over its increment.
  - Both counters wrap at 2^XLEN-1 to 0.
- Minimum trap-to-next-commit latency is 2 cycles (accept cycle + redirect cycle with redirect_ready=1).

Decomposition:
- Shared package holds:
  - CSR address constants.
  - Exception/interrupt code constants.
  - csr_op encodings.
  - mstatus bit indices.
  - mtvec MODE encodings.
  - FSM state typedef {IDLE, REDIR}.
- One natural sub-module, csr_trap_prio: combinational interrupt priority encoder producing int_req and code.

Test Plan:
- CSRRW mtvec=0x8000_0001 with VECTORED_EN=1, then irq_timer=1, mie=0x80, MIE=1, next commit at pc 0x100:
  - mepc=0x100, mcause=0x8000_0000_0000_0007.
  - redirect_pc=0x8000_001C, MIE=0, MPIE=1.
- ecall at pc 0x200 (exc=1, cause=11) with redirect_ready held 0 for 3 cycles:
  - commit_ready=0 and redirect_pc stable for 3 cycles; release after ready.
  - minstret unchanged.
- Simultaneous irq_ext and irq_sw both enabled, plus exception at commit:
  - Interrupt is taken, mcause code 11, mtval=0.
- mret with mepc=0x300, MPIE=1:
  - redirect_pc=0x300, MIE=1, MPIE=1, minstret+1.
- CSRRS mcountinhibit=0x1, then CSRRW mcycle=0xFFFF_FFFF_FFFF_FFFF, CSRRC mcountinhibit=0x1:
  - mcycle holds while inhibited, then wraps to 0.
- Read unknown address 0x7C0 → rd_illegal=1, rd_data=0. Assert rst=0 during REDIR → redirect_valid=0 next cycle, all CSRs at reset values.
